// File: rtl/regbank_scheduler_if.sv
// Issue and writeback channels between the pipeline and regbank_scheduler.
// Requesters drive the master side; the scheduler returns ready/grants on the slave side.
interface regbank_scheduler_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 3
);
    logic              iss_valid;
    logic [SEL_W-1:0]  iss_dest;
    logic [SEL_W-1:0]  iss_src1;
    logic [SEL_W-1:0]  iss_src2;
    logic              iss_use_src2;
    logic              iss_ready;

    logic              alu_wb_valid;
    logic [SEL_W-1:0]  alu_wb_dest;
    logic [DATA_W-1:0] alu_wb_data;
    logic              alu_wb_grant;

    logic              mem_wb_valid;
    logic [SEL_W-1:0]  mem_wb_dest;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_grant;

    modport master (
        output iss_valid, iss_dest, iss_src1, iss_src2, iss_use_src2,
        output alu_wb_valid, alu_wb_dest, alu_wb_data,
        output mem_wb_valid, mem_wb_dest, mem_wb_data,
        input  iss_ready, alu_wb_grant, mem_wb_grant
    );

    modport slave (
        input  iss_valid, iss_dest, iss_src1, iss_src2, iss_use_src2,
        input  alu_wb_valid, alu_wb_dest, alu_wb_data,
        input  mem_wb_valid, mem_wb_dest, mem_wb_data,
        output iss_ready, alu_wb_grant, mem_wb_grant
    );
endinterface

// File: rtl/regbank_scheduler.sv
// Busy scoreboard with RAW/WAW issue stall and round-robin arbitration of
// ALU and load writebacks onto the register bank's single write port.
module regbank_scheduler #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    regbank_scheduler_if.slave bus,
    output logic              rb_we,
    output logic [SEL_W-1:0]  rb_destreg_sel,
    output logic [DATA_W-1:0] rb_wdata,
    output logic [NREGS-1:0]  busy,
    output logic [15:0]       stall_count,
    output logic              wb_err
);
    localparam logic PTR_ALU = 1'b0;
    localparam logic PTR_MEM = 1'b1;

    logic              last_grant;
    logic              alu_grant;
    logic              mem_grant;
    logic              wb_fire;
    logic [SEL_W-1:0]  wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              ready;
    logic              issue_fire;
    logic              stall;
    logic [NREGS-1:0]  busy_nxt;

    // Grants are withheld during reset so held requests survive it.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!reset) begin
            if (bus.alu_wb_valid && bus.mem_wb_valid) begin
                alu_grant = (last_grant == PTR_MEM);
                mem_grant = (last_grant == PTR_ALU);
            end else begin
                alu_grant = bus.alu_wb_valid;
                mem_grant = bus.mem_wb_valid;
            end
        end
    end

    assign wb_fire          = alu_grant | mem_grant;
    assign wb_dest          = alu_grant ? bus.alu_wb_dest : bus.mem_wb_dest;
    assign wb_data          = alu_grant ? bus.alu_wb_data : bus.mem_wb_data;
    assign bus.alu_wb_grant = alu_grant;
    assign bus.mem_wb_grant = mem_grant;

    assign ready = !busy[bus.iss_dest] && !busy[bus.iss_src1]
                   && !(bus.iss_use_src2 && busy[bus.iss_src2]);
    assign bus.iss_ready = ready;
    assign issue_fire    = bus.iss_valid && ready;
    assign stall         = bus.iss_valid && !ready;

    // Clear before set; a same-register collision only arises on an erroneous writeback.
    always_comb begin
        busy_nxt = busy;
        if (wb_fire) begin
            busy_nxt[wb_dest] = 1'b0;
        end
        if (issue_fire) begin
            busy_nxt[bus.iss_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy           <= '0;
            rb_we          <= 1'b0;
            rb_destreg_sel <= '0;
            rb_wdata       <= '0;
            stall_count    <= '0;
            wb_err         <= 1'b0;
            last_grant     <= PTR_MEM;
        end else begin
            busy  <= busy_nxt;
            rb_we <= wb_fire;
            if (wb_fire) begin
                rb_destreg_sel <= wb_dest;
                rb_wdata       <= wb_data;
                last_grant     <= mem_grant ? PTR_MEM : PTR_ALU;
                if (!busy[wb_dest]) begin
                    wb_err <= 1'b1;
                end
            end
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_regbank_scheduler.sv
// Scoreboard bench for regbank_scheduler: directed scenarios then randomized traffic
// against a cycle-level reference model; writes are checked by a separate monitor.
module tb_regbank_scheduler;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned SEL_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              rb_we;
    logic [SEL_W-1:0]  rb_destreg_sel;
    logic [DATA_W-1:0] rb_wdata;
    logic [NREGS-1:0]  busy;
    logic [15:0]       stall_count;
    logic              wb_err;

    always #5 clk = ~clk;

    regbank_scheduler_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    regbank_scheduler #(.DATA_W(DATA_W), .NREGS(NREGS), .SEL_W(SEL_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rb_we          (rb_we),
        .rb_destreg_sel (rb_destreg_sel),
        .rb_wdata       (rb_wdata),
        .busy           (busy),
        .stall_count    (stall_count),
        .wb_err         (wb_err)
    );

    typedef struct {
        int          due;
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    wr_t  wq[$];
    bit   glog[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    // reference model state
    logic [7:0]  m_busy;
    bit          m_last_mem;
    int          m_stall;
    bit          m_err;
    logic [2:0]  m_sel;
    logic [15:0] m_wd;

    // stimulus state: requesters hold until granted
    bit          i_valid, i_use2;
    logic [2:0]  i_dest, i_s1, i_s2;
    bit          a_pend, l_pend;
    logic [2:0]  a_dest, l_dest;
    logic [15:0] a_data, l_data;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // write-port monitor: every rb_we must match the oldest predicted write, on its cycle
    always @(negedge clk) begin
        if (rb_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("rb_we_spurious", 32'(rb_we), 32'd0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_cycle", 32'(cyc), 32'(w.due));
                check("wr_sel", 32'(rb_destreg_sel), 32'(w.dest));
                check("wr_data", 32'(rb_wdata), 32'(w.data));
            end
        end else if (wq.size() > 0 && wq[0].due == cyc) begin
            check("rb_we_missing", 32'(rb_we), 32'd1);
            void'(wq.pop_front());
        end
    end

    task automatic cycle(input bit rst);
        bit exp_ready, g_alu, g_mem, g_any;
        logic [2:0]  gd;
        logic [15:0] gdat;
        logic [7:0]  nb;
        reset            = rst;
        bus.iss_valid    = i_valid;
        bus.iss_dest     = i_dest;
        bus.iss_src1     = i_s1;
        bus.iss_src2     = i_s2;
        bus.iss_use_src2 = i_use2;
        bus.alu_wb_valid = a_pend;
        bus.alu_wb_dest  = a_dest;
        bus.alu_wb_data  = a_data;
        bus.mem_wb_valid = l_pend;
        bus.mem_wb_dest  = l_dest;
        bus.mem_wb_data  = l_data;
        @(negedge clk);
        check("busy", 32'(busy), 32'(m_busy));
        check("stall_count", 32'(stall_count), 32'(m_stall));
        check("wb_err", 32'(wb_err), 32'(m_err));
        check("rb_sel_hold", 32'(rb_destreg_sel), 32'(m_sel));
        check("rb_wdata_hold", 32'(rb_wdata), 32'(m_wd));
        exp_ready = !(m_busy[i_dest] || m_busy[i_s1] || (i_use2 && m_busy[i_s2]));
        // winner: sole requester, else whoever did not win last time
        g_alu = 1'b0;
        g_mem = 1'b0;
        if (!rst) begin
            if (a_pend && l_pend) begin
                if (m_last_mem) g_alu = 1'b1; else g_mem = 1'b1;
            end else begin
                g_alu = a_pend;
                g_mem = l_pend;
            end
        end
        g_any = g_alu || g_mem;
        if (!rst) begin
            check("iss_ready", 32'(bus.iss_ready), 32'(exp_ready));
            check("alu_grant", 32'(bus.alu_wb_grant), 32'(g_alu));
            check("mem_grant", 32'(bus.mem_wb_grant), 32'(g_mem));
        end
        if (rst) begin
            m_busy = '0; m_last_mem = 1'b1; m_stall = 0; m_err = 1'b0; m_sel = '0; m_wd = '0;
        end else begin
            nb = m_busy;
            if (g_any) begin
                gd   = g_alu ? a_dest : l_dest;
                gdat = g_alu ? a_data : l_data;
                if (!m_busy[gd]) m_err = 1'b1;
                nb[gd] = 1'b0;
                wq.push_back('{due: cyc + 1, dest: gd, data: gdat});
                glog.push_back(g_mem);
                m_last_mem = g_mem;
                m_sel = gd;
                m_wd  = gdat;
                if (g_alu) a_pend = 1'b0; else l_pend = 1'b0;
            end
            if (i_valid && exp_ready) nb[i_dest] = 1'b1;
            if (i_valid && !exp_ready && m_stall < 65535) m_stall++;
            m_busy = nb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input bit v, input logic [2:0] d, input logic [2:0] s1,
                             input logic [2:0] s2, input bit u2);
        i_valid = v; i_dest = d; i_s1 = s1; i_s2 = s2; i_use2 = u2;
    endtask

    initial begin
        int ai, li;
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        a_pend = 0; l_pend = 0; a_dest = 0; l_dest = 0; a_data = 0; l_data = 0;
        m_busy = 0; m_last_mem = 1; m_stall = 0; m_err = 0; m_sel = 0; m_wd = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1);
        cycle(1'b1);

        // single issue sets one busy bit
        set_issue(1'b1, 3'd3, 3'd0, 3'd1, 1'b1);
        cycle(1'b0);
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        check("tp1_busy", 32'(busy), 32'h08);

        // RAW stall on r3 for 4 cycles; ALU writeback on the 4th, issue proceeds after
        set_issue(1'b1, 3'd4, 3'd3, 3'd0, 1'b0);
        repeat (3) cycle(1'b0);
        a_pend = 1; a_dest = 3'd3; a_data = 16'h0F0F;
        cycle(1'b0);
        check("tp2_stall", 32'(stall_count), 32'd4);
        check("tp2_we", 32'(rb_we), 32'd1);
        check("tp2_sel", 32'(rb_destreg_sel), 32'd3);
        check("tp2_data", 32'(rb_wdata), 32'h0F0F);
        check("tp2_busy3", 32'(busy[3]), 32'd0);
        cycle(1'b0);
        check("tp2_issued", 32'(busy), 32'h10);
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);

        // contention after reset: ALU first, then MEM
        cycle(1'b1);
        set_issue(1'b1, 3'd2, 3'd0, 3'd0, 1'b0); cycle(1'b0);
        set_issue(1'b1, 3'd5, 3'd0, 3'd0, 1'b0); cycle(1'b0);
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        a_pend = 1; a_dest = 3'd2; a_data = 16'hAAAA;
        l_pend = 1; l_dest = 3'd5; l_data = 16'h5555;
        cycle(1'b0);
        check("tp3_first_sel", 32'(rb_destreg_sel), 32'd2);
        cycle(1'b0);
        check("tp3_second_sel", 32'(rb_destreg_sel), 32'd5);
        check("tp3_second_data", 32'(rb_wdata), 32'h5555);
        check("tp3_busy", 32'(busy), 32'h00);

        // back-to-back contention alternates
        for (int r = 0; r < 6; r++) begin
            set_issue(1'b1, 3'(r), 3'(r), 3'(r), 1'b0);
            cycle(1'b0);
        end
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        glog.delete();
        ai = 0; li = 0;
        for (int k = 0; k < 6; k++) begin
            if (!a_pend && ai < 3) begin a_pend = 1; a_dest = 3'(2 * ai); a_data = 16'(16'h100 + ai); ai++; end
            if (!l_pend && li < 3) begin l_pend = 1; l_dest = 3'(2 * li + 1); l_data = 16'(16'h200 + li); li++; end
            cycle(1'b0);
        end
        check("tp4_ngrants", 32'(glog.size()), 32'd6);
        for (int k = 0; k < glog.size(); k++) check("tp4_alternate", 32'(glog[k]), 32'(k % 2));
        check("tp4_busy", 32'(busy), 32'h00);

        // writeback to an idle register still writes and flags
        a_pend = 1; a_dest = 3'd6; a_data = 16'h1234;
        cycle(1'b0);
        check("tp5_we", 32'(rb_we), 32'd1);
        check("tp5_sel", 32'(rb_destreg_sel), 32'd6);
        check("tp5_err", 32'(wb_err), 32'd1);
        repeat (3) cycle(1'b0);
        check("tp5_err_sticky", 32'(wb_err), 32'd1);

        // reset the cycle after a grant with every register busy
        for (int r = 0; r < 8; r++) begin
            set_issue(1'b1, 3'(r), 3'(r), 3'(r), 1'b0);
            cycle(1'b0);
        end
        check("tp6_allbusy", 32'(busy), 32'hFF);
        set_issue(1'b1, 3'd0, 3'd1, 3'd2, 1'b1);
        a_pend = 1; a_dest = 3'd1; a_data = 16'hBEEF;
        cycle(1'b0);
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        cycle(1'b1);
        check("tp6_we", 32'(rb_we), 32'd0);
        check("tp6_busy", 32'(busy), 32'h00);
        check("tp6_stall", 32'(stall_count), 32'd0);
        check("tp6_err", 32'(wb_err), 32'd0);

        // randomized traffic, occasional reset with requests held across it
        for (int k = 0; k < 3000; k++) begin
            logic [2:0] r;
            set_issue(1'($urandom % 2), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom % 2));
            if (!a_pend && ($urandom % 3 == 0)) begin
                r = 3'($urandom);
                if (m_busy != 0 && ($urandom % 8 != 0)) while (!m_busy[r]) r = r + 3'd1;
                a_pend = 1; a_dest = r; a_data = 16'($urandom);
            end
            if (!l_pend && ($urandom % 3 == 0)) begin
                r = 3'($urandom);
                if (m_busy != 0 && ($urandom % 8 != 0)) while (!m_busy[r]) r = r + 3'd1;
                l_pend = 1; l_dest = r; l_data = 16'($urandom);
            end
            cycle(($urandom % 250) == 0);
        end
        set_issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        repeat (4) cycle(1'b0);
        check("writes_drained", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regbank_scheduler.md
Name: regbank_scheduler

Overview:
- Controller in front of `register_bank`.
- Keeps a busy scoreboard of the 8 registers. It stalls instruction issue on RAW and WAW hazards.
- The register bank has a single write port. Two writeback requesters share it: the ALU and the memory/load unit. Round-robin arbitration decides between them.
- The block drives the bank's `destreg_sel` and the write data, and asserts the write enable.

Parameters:
- DATA_W, 16, register and writeback data width.
- NREGS, 8, number of registers in the bank.
- SEL_W, 3, register select width (log2 of NREGS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iss_valid  in  1  issue stage presents an instruction.
- iss_dest  in  SEL_W  destination register of the issuing instruction.
- iss_src1  in  SEL_W  first source register.
- iss_src2  in  SEL_W  second source register.
- iss_use_src2  in  1  instruction reads src2.
- iss_ready  out  1  combinational: the issue may proceed this cycle.
- alu_wb_valid  in  1  ALU writeback request.
- alu_wb_dest  in  SEL_W  ALU writeback register.
- alu_wb_data  in  DATA_W  ALU result.
- alu_wb_grant  out  1  combinational grant to the ALU.
- mem_wb_valid  in  1  load-unit writeback request.
- mem_wb_dest  in  SEL_W  load writeback register.
- mem_wb_data  in  DATA_W  load data.
- mem_wb_grant  out  1  combinational grant to the load unit.
- rb_we  out  1  registered write enable to the register bank.
- rb_destreg_sel  out  SEL_W  registered write select.
- rb_wdata  out  DATA_W  registered write data (the bank's ALU_result input).
- busy  out  NREGS  scoreboard vector; bit i set means register i has a write pending.
- stall_count  out  16  saturating count of stalled issue cycles.
- wb_err  out  1  sticky flag: a writeback was granted to a non-busy register.

Behaviour:
- Reset values: busy=0, rb_we=0, rb_destreg_sel=0, rb_wdata=0, stall_count=0, wb_err=0, round-robin last-grant pointer=MEM (so the ALU wins the first contention).
- Hazard check: `iss_ready = !busy[iss_dest] && !busy[iss_src1] && !(iss_use_src2 && busy[iss_src2])`.
- Issue acceptance: an issue is accepted when iss_valid && iss_ready. The next cycle busy[iss_dest] is 1.
- Stall counting: stall_count increments on every cycle with iss_valid && !iss_ready. It saturates at 16'hFFFF.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not named by the last-grant pointer is granted.
  - The pointer updates to the granted requester on every grant. No grant leaves the pointer unchanged.
  - At most one grant per cycle.
  - A requester holds valid, dest and data stable until granted. A grant means its request is consumed this cycle.
- Write port, 1-cycle latency: in the cycle after a grant, rb_we=1 and rb_destreg_sel/rb_wdata carry the granted request's dest and data. Otherwise rb_we=0 and the select and data hold their last values.
- Scoreboard clear: busy[dest] of the granted request clears at the grant edge, so it reads 0 on the same cycle rb_we is presented.
- Same-cycle issue and grant to the same register: the issue sees the old busy=1 and stalls. The next cycle it proceeds, since busy is now 0.
- Same-cycle set and clear on different registers: both take effect.
- Same-cycle set and clear on the same register: impossible by the WAW check.
- Granted writeback to a register whose busy bit is 0: the write still occurs and wb_err sets. wb_err stays set until reset.
- Reset mid-operation: pending busy bits, an in-flight rb_we and the counters all clear next edge. Requests held across reset are arbitrated normally afterwards.

Test Plan:
- Reset, then issue dest=3 src1=0 src2=1 with iss_use_src2=1 → iss_ready=1; next cycle busy=8'b0000_1000.
- With busy[3]=1, issue src1=3 for 4 cycles, then ALU writeback dest=3 data=16'h0F0F → iss_ready=0 for 4 cycles and stall_count=4. alu_wb_grant=1; next cycle rb_we=1, rb_destreg_sel=3, rb_wdata=16'h0F0F, busy[3]=0; the issue is accepted the cycle after the grant.
- Registers 2 and 5 busy; ALU (dest=2, 16'hAAAA) and MEM (dest=5, 16'h5555) request together after reset → ALU granted first, MEM next cycle. rb writes reg2 then reg5 on consecutive cycles; busy ends at 0.
- ALU and MEM continuously valid for 6 cycles (with matching busy bits set) → grants alternate ALU, MEM, ALU, MEM, ALU, MEM.
- ALU writeback dest=6 while busy[6]=0 → the write occurs with rb_we=1 and rb_destreg_sel=6; wb_err=1 and stays 1 until reset.
- Reset asserted the cycle after a grant, with busy=8'hFF → next cycle rb_we=0, busy=0, stall_count=0, wb_err=0.
